// File: rtl/sdrc_pkg.sv
// Shared SDRAM-controller definitions: transfer state encoding and default widths.
package sdrc_pkg;

  localparam int unsigned CNT_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LAST   = 2'd2
  } xfr_state_e;

endpackage

// File: rtl/sdrc_xfr_dec.sv
// Combinational W-bit decrement-by-one used for the remaining-beat count.
module sdrc_xfr_dec #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout_c
);

  assign dout_c = din - W'(1);

endmodule

// File: rtl/sdrc_xfr_dcnt.sv
// Transfer beat counter: tracks remaining beats and column address of a burst,
// with load/ack, done and abort pulses.
module sdrc_xfr_dcnt
  import sdrc_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             xfr_ld,
  input  logic [CNT_W-1:0] xfr_len,
  input  logic [CNT_W-1:0] xfr_col,
  input  logic             xfr_beat,
  input  logic             xfr_abort,
  output logic             xfr_ld_ack,
  output logic             xfr_busy,
  output logic [CNT_W-1:0] xfr_rem,
  output logic [CNT_W-1:0] xfr_addr,
  output logic             xfr_last,
  output logic             xfr_done,
  output logic             xfr_aborted
);

  xfr_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             abt_q, abt_d;
  logic [CNT_W-1:0] rem_dec_c;

  sdrc_xfr_dec #(.W(CNT_W)) u_dec (
    .din    (rem_q),
    .dout_c (rem_dec_c)
  );

  // Next-state and pulse generation; abort outranks a same-cycle beat.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfr_ld) begin
          ack_d = 1'b1;
          if (xfr_len == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = xfr_len;
            addr_d  = xfr_col;
            state_d = (xfr_len == CNT_W'(1)) ? ST_LAST : ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (xfr_abort) begin
          rem_d   = '0;
          abt_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (xfr_beat) begin
          rem_d  = rem_dec_c;
          addr_d = addr_q + CNT_W'(1);
          if (rem_dec_c == CNT_W'(1)) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (xfr_abort) begin
          rem_d   = '0;
          abt_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (xfr_beat) begin
          rem_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  assign xfr_ld_ack  = ack_q;
  assign xfr_done    = done_q;
  assign xfr_aborted = abt_q;
  assign xfr_rem     = rem_q;
  assign xfr_addr    = addr_q;
  assign xfr_last    = (state_q == ST_LAST);
  assign xfr_busy    = (state_q == ST_ACTIVE) || (state_q == ST_LAST);

endmodule

// File: tb/tb_sdrc_xfr_dcnt.sv
// Scoreboard bench for sdrc_xfr_dcnt: stimulus queues hand-computed output snapshots,
// a monitor pops and compares them against the DUT.
module tb_sdrc_xfr_dcnt;

  localparam int unsigned W = 12;

  typedef struct packed {
    logic         ack;
    logic         busy;
    logic [W-1:0] rem;
    logic [W-1:0] addr;
    logic         last;
    logic         done;
    logic         abt;
  } snap_t;

  logic         clk;
  logic         reset_n;
  logic         xfr_ld;
  logic [W-1:0] xfr_len;
  logic [W-1:0] xfr_col;
  logic         xfr_beat;
  logic         xfr_abort;
  logic         xfr_ld_ack;
  logic         xfr_busy;
  logic [W-1:0] xfr_rem;
  logic [W-1:0] xfr_addr;
  logic         xfr_last;
  logic         xfr_done;
  logic         xfr_aborted;

  snap_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  mon_trig = 1'b0;

  sdrc_xfr_dcnt #(.CNT_W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .xfr_ld      (xfr_ld),
    .xfr_len     (xfr_len),
    .xfr_col     (xfr_col),
    .xfr_beat    (xfr_beat),
    .xfr_abort   (xfr_abort),
    .xfr_ld_ack  (xfr_ld_ack),
    .xfr_busy    (xfr_busy),
    .xfr_rem     (xfr_rem),
    .xfr_addr    (xfr_addr),
    .xfr_last    (xfr_last),
    .xfr_done    (xfr_done),
    .xfr_aborted (xfr_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expected snapshot per sample point.
  initial begin
    forever begin
      @(negedge clk or posedge mon_trig);
      if (exp_q.size() != 0) begin
        snap_t e;
        snap_t a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {xfr_ld_ack, xfr_busy, xfr_rem, xfr_addr, xfr_last, xfr_done, xfr_aborted};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got ack=%b busy=%b rem=%h addr=%h last=%b done=%b abt=%b, want ack=%b busy=%b rem=%h addr=%h last=%b done=%b abt=%b",
                   n, a.ack, a.busy, a.rem, a.addr, a.last, a.done, a.abt,
                   e.ack, e.busy, e.rem, e.addr, e.last, e.done, e.abt);
        end
      end
    end
  end

  task automatic push(input string n, input logic ack, input logic busy, input logic [W-1:0] rem,
                      input logic [W-1:0] addr, input logic last, input logic done, input logic abt);
    snap_t s;
    s = '{ack: ack, busy: busy, rem: rem, addr: addr, last: last, done: done, abt: abt};
    exp_q.push_back(s);
    name_q.push_back(n);
  endtask

  // One cycle of stimulus plus the expected outputs after the following rising edge.
  task automatic step(input string n, input logic ld, input logic [W-1:0] len, input logic [W-1:0] col,
                      input logic beat, input logic abort,
                      input logic ack, input logic busy, input logic [W-1:0] rem,
                      input logic [W-1:0] addr, input logic last, input logic done, input logic abt);
    @(negedge clk);
    #1;
    xfr_ld    = ld;
    xfr_len   = len;
    xfr_col   = col;
    xfr_beat  = beat;
    xfr_abort = abort;
    push(n, ack, busy, rem, addr, last, done, abt);
  endtask

  task automatic trig_check();
    mon_trig = 1'b1;
    #1;
    mon_trig = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    xfr_ld    = 1'b0;
    xfr_len   = '0;
    xfr_col   = '0;
    xfr_beat  = 1'b0;
    xfr_abort = 1'b0;
    #2;
    push("reset_state", 0, 0, 12'h000, 12'h000, 0, 0, 0);
    trig_check();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // len=4 from 0x010
    step("l4_load",  1, 12'd4, 12'h010, 0, 0,  1, 1, 12'd4, 12'h010, 0, 0, 0);
    step("l4_b1",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd3, 12'h011, 0, 0, 0);
    step("l4_b2",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd2, 12'h012, 0, 0, 0);
    step("l4_b3",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd1, 12'h013, 1, 0, 0);
    step("l4_b4",    0, 12'd0, 12'h000, 1, 0,  0, 0, 12'd0, 12'h013, 0, 1, 0);
    step("l4_idle",  0, 12'd0, 12'h000, 0, 0,  0, 0, 12'd0, 12'h013, 0, 0, 0);

    // address wrap
    step("wr_load",  1, 12'd3, 12'hFFE, 0, 0,  1, 1, 12'd3, 12'hFFE, 0, 0, 0);
    step("wr_b1",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd2, 12'hFFF, 0, 0, 0);
    step("wr_b2",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd1, 12'h000, 1, 0, 0);
    step("wr_b3",    0, 12'd0, 12'h000, 1, 0,  0, 0, 12'd0, 12'h000, 0, 1, 0);

    // zero-length load, then beat/abort in idle
    step("z_load",   1, 12'd0, 12'h555, 0, 0,  1, 0, 12'd0, 12'h000, 0, 1, 0);
    step("z_idle",   0, 12'd0, 12'h000, 0, 0,  0, 0, 12'd0, 12'h000, 0, 0, 0);
    step("idle_bt",  0, 12'd0, 12'h000, 1, 0,  0, 0, 12'd0, 12'h000, 0, 0, 0);
    step("idle_ab",  0, 12'd0, 12'h000, 0, 1,  0, 0, 12'd0, 12'h000, 0, 0, 0);

    // abort with coincident beat
    step("ab_load",  1, 12'd8, 12'h200, 0, 0,  1, 1, 12'd8, 12'h200, 0, 0, 0);
    step("ab_b1",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd7, 12'h201, 0, 0, 0);
    step("ab_b2",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd6, 12'h202, 0, 0, 0);
    step("ab_abort", 0, 12'd0, 12'h000, 1, 1,  0, 0, 12'd0, 12'h202, 0, 0, 1);
    step("ab_idle",  0, 12'd0, 12'h000, 0, 0,  0, 0, 12'd0, 12'h202, 0, 0, 0);

    // load while busy is ignored
    step("ig_load",  1, 12'd5, 12'h300, 0, 0,  1, 1, 12'd5, 12'h300, 0, 0, 0);
    step("ig_ldbt",  1, 12'd9, 12'h007, 1, 0,  0, 1, 12'd4, 12'h301, 0, 0, 0);
    step("ig_ld",    1, 12'd9, 12'h007, 0, 0,  0, 1, 12'd4, 12'h301, 0, 0, 0);
    step("ig_b2",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd3, 12'h302, 0, 0, 0);
    step("ig_b3",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd2, 12'h303, 0, 0, 0);
    step("ig_b4",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd1, 12'h304, 1, 0, 0);
    step("ig_ldlst", 1, 12'd9, 12'h007, 0, 0,  0, 1, 12'd1, 12'h304, 1, 0, 0);
    step("ig_b5",    0, 12'd0, 12'h000, 1, 0,  0, 0, 12'd0, 12'h304, 0, 1, 0);

    // single-beat load aborted from LAST
    step("one_load", 1, 12'd1, 12'h0AB, 0, 0,  1, 1, 12'd1, 12'h0AB, 1, 0, 0);
    step("one_abt",  0, 12'd0, 12'h000, 0, 1,  0, 0, 12'd0, 12'h0AB, 0, 0, 1);

    // reset in mid-transfer, then load on first edge after release
    step("rs_load",  1, 12'd5, 12'h400, 0, 0,  1, 1, 12'd5, 12'h400, 0, 0, 0);
    step("rs_b1",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd4, 12'h401, 0, 0, 0);
    step("rs_b2",    0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd3, 12'h402, 0, 0, 0);
    @(negedge clk);
    #1;
    reset_n   = 1'b0;
    xfr_ld    = 1'b1;
    xfr_len   = 12'd2;
    xfr_col   = 12'h100;
    xfr_beat  = 1'b0;
    xfr_abort = 1'b0;
    #1;
    push("rs_async", 0, 0, 12'd0, 12'h000, 0, 0, 0);
    trig_check();
    #1 reset_n = 1'b1;
    push("rs_first", 1, 1, 12'd2, 12'h100, 0, 0, 0);
    step("rs_n_b1",  0, 12'd0, 12'h000, 1, 0,  0, 1, 12'd1, 12'h101, 1, 0, 0);
    step("rs_n_b2",  0, 12'd0, 12'h000, 1, 0,  0, 0, 12'd0, 12'h101, 0, 1, 0);
    step("rs_idle",  0, 12'd0, 12'h000, 0, 0,  0, 0, 12'd0, 12'h101, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected snapshots left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdrc_xfr_dcnt.md
SDRC_XFR_DCNT -- requirements
Module: sdrc_xfr_dcnt

Interface
REQ-001 The block SHALL have parameter CNT_W, default 12, giving the width of the length counter and the column address.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port xfr_ld, input, 1 bit: request to load a new transfer.
REQ-005 The block SHALL have port xfr_len, input, CNT_W bits: beat count of the transfer being loaded.
REQ-006 The block SHALL have port xfr_col, input, CNT_W bits: starting column address of the transfer.
REQ-007 The block SHALL have port xfr_beat, input, 1 bit: one data beat accepted this cycle.
REQ-008 The block SHALL have port xfr_abort, input, 1 bit: terminate the transfer in progress.
REQ-009 The block SHALL have port xfr_ld_ack, output, 1 bit: one-cycle pulse confirming an accepted load.
REQ-010 The block SHALL have port xfr_busy, output, 1 bit: a transfer is in progress.
REQ-011 The block SHALL have port xfr_rem, output, CNT_W bits: beats remaining in the transfer.
REQ-012 The block SHALL have port xfr_addr, output, CNT_W bits: column address of the current beat.
REQ-013 The block SHALL have port xfr_last, output, 1 bit: the current beat is the final beat.
REQ-014 The block SHALL have port xfr_done, output, 1 bit: one-cycle pulse when the final beat completes.
REQ-015 The block SHALL have port xfr_aborted, output, 1 bit: one-cycle pulse when an abort is taken.

Function
REQ-016 The block SHALL implement the state machine IDLE, ACTIVE, LAST; xfr_busy SHALL be asserted in ACTIVE and in LAST.
REQ-017 In IDLE, xfr_ld with xfr_len>1 SHALL, on the next edge, set xfr_rem=xfr_len and xfr_addr=xfr_col, pulse xfr_ld_ack, and enter ACTIVE.
REQ-018 In IDLE, xfr_ld with xfr_len==1 SHALL perform the same load and enter LAST.
REQ-019 In IDLE, xfr_ld with xfr_len==0 SHALL pulse xfr_ld_ack and xfr_done on the next cycle, leave xfr_rem and xfr_addr unchanged, and remain in IDLE.
REQ-020 xfr_ld outside IDLE SHALL be ignored: no ack and no state change.
REQ-021 In ACTIVE, each xfr_beat SHALL decrement xfr_rem by 1 and increment xfr_addr by 1 modulo 2^CNT_W (0xFFF wraps to 0x000); the state SHALL become LAST when the new xfr_rem equals 1.
REQ-022 In LAST, xfr_beat SHALL set xfr_rem=0, pulse xfr_done on the next cycle, and return the block to IDLE; xfr_addr SHALL hold its value.
REQ-023 xfr_last SHALL be asserted if and only if the state is LAST, decoded directly from the state register.
REQ-024 xfr_abort in ACTIVE or LAST SHALL, on the next edge, set xfr_rem=0, return the block to IDLE, and pulse xfr_aborted; xfr_done SHALL NOT be pulsed.
REQ-025 When xfr_abort and xfr_beat are asserted in the same cycle, xfr_abort SHALL take priority and the beat SHALL be discarded.
REQ-026 xfr_abort in IDLE SHALL have no effect.
REQ-027 xfr_beat in IDLE SHALL have no effect.
REQ-028 All outputs SHALL be registered, except xfr_last and xfr_busy, which are decoded from the state register; latency from input to output SHALL be one cycle.

Reset
REQ-029 While reset_n=0, the block SHALL force state=IDLE, xfr_rem=0 and xfr_addr=0, and hold xfr_ld_ack, xfr_done, xfr_aborted, xfr_busy and xfr_last at 0.
REQ-030 Assertion of reset in the middle of a transfer SHALL discard that transfer with no done or aborted pulse.
REQ-031 After reset_n rises, the first edge SHALL accept xfr_ld.

Structure
REQ-032 The state enumeration and the CNT_W default SHALL be defined in the shared package sdrc_pkg.
REQ-033 The decrement of xfr_rem SHALL be implemented by one sub-module, sdrc_xfr_dec, a CNT_W-bit combinational decrementer; the address increment SHALL reuse the existing incrementer.

Verification
REQ-034 Load len=4, col=0x010, then 4 consecutive beats -> xfr_addr steps 0x010..0x013; xfr_rem steps 4,3,2,1,0; xfr_last is high during the 4th beat; xfr_done pulses once; xfr_busy falls.
REQ-035 Load len=3, col=0xFFE, then 3 beats -> xfr_addr steps 0xFFE, 0xFFF, 0x000.
REQ-036 Load len=0 -> xfr_ld_ack and xfr_done pulse in the same cycle; xfr_busy stays 0.
REQ-037 Load len=8, give 2 beats, then abort asserted together with a beat -> xfr_rem=0, xfr_aborted pulses, no xfr_done, xfr_addr=col+2.
REQ-038 Load len=5, give 2 beats, then pulse reset_n low -> all outputs are 0 immediately; a new load on the first cycle after reset is acked.
REQ-039 Assert xfr_ld while in ACTIVE with len=9 -> no ack, and xfr_rem continues its original countdown.
